// File: rtl/sdcard_writeback.sv
// Dumps NUM_WORDS 128-bit RAM words to the SD card as 512-byte blocks, byte 0 of each word first.
// Latency: sd_hndshk_o rises one cycle after sd_hndshk_i is sampled high; one RAM read per 16 bytes.
// Backpressure: stalls on ram_rdy, on sd_busy at block start/end, and on every controller byte handshake.
module sdcard_writeback #(
    parameter logic [21:0] NUM_WORDS   = 22'h99BDE,
    parameter logic [21:0] RAM_BASE    = 22'h3F0000,
    parameter logic [31:0] START_BLOCK = 32'h0,
    parameter logic        SDHC        = 1'b1
) (
    input  logic         clk50,
    input  logic         reset_n,
    input  logic         start,
    output logic         ram_re,
    output logic [21:0]  ram_address,
    input  logic [127:0] ram_data,
    input  logic         ram_rdy,
    output logic         sd_wr,
    output logic         sd_continue,
    output logic [31:0]  sd_block_addr,
    output logic [7:0]   sd_data,
    output logic         sd_hndshk_o,
    input  logic         sd_hndshk_i,
    input  logic         sd_busy,
    input  logic [15:0]  sd_error,
    output logic         busy,
    output logic         done,
    output logic         error
);

    typedef enum logic [3:0] {
        WAIT_INIT,
        IDLE,
        FETCH,
        BLK_START,
        BYTE_WAIT,
        BYTE_ACK,
        BLK_END,
        DONE,
        ERROR
    } state_t;

    state_t       state, state_nxt;
    logic [22:0]  word_idx, word_nxt;
    logic [8:0]   byte_cnt, byte_nxt;
    logic [31:0]  blk_idx, blk_nxt;
    logic [127:0] shreg, shreg_nxt;
    logic [7:0]   data_nxt;
    logic         hs_nxt;
    logic [31:0]  addr_nxt;

    logic         word_past;
    logic [31:0]  blk_num;
    logic [31:0]  blk_addr_fmt;

    // Words beyond the dump length are padding: no RAM access, zero data.
    assign word_past    = (word_idx >= {1'b0, NUM_WORDS});
    assign blk_num      = START_BLOCK + blk_idx;
    assign blk_addr_fmt = SDHC ? blk_num : {blk_num[22:0], 9'b0};

    assign ram_re      = (state == FETCH) && !word_past;
    assign ram_address = RAM_BASE + word_idx[21:0];
    assign sd_wr       = (state == BLK_START);
    assign sd_continue = 1'b0;
    assign busy        = (state == FETCH) || (state == BLK_START) || (state == BYTE_WAIT) ||
                         (state == BYTE_ACK) || (state == BLK_END);
    assign done        = (state == DONE);
    assign error       = (state == ERROR);

    // State and datapath registers; reset abandons any dump in flight.
    always_ff @(posedge clk50 or negedge reset_n) begin
        if (!reset_n) begin
            state         <= WAIT_INIT;
            word_idx      <= '0;
            byte_cnt      <= '0;
            blk_idx       <= '0;
            shreg         <= '0;
            sd_data       <= '0;
            sd_hndshk_o   <= 1'b0;
            sd_block_addr <= '0;
        end else begin
            state         <= state_nxt;
            word_idx      <= word_nxt;
            byte_cnt      <= byte_nxt;
            blk_idx       <= blk_nxt;
            shreg         <= shreg_nxt;
            sd_data       <= data_nxt;
            sd_hndshk_o   <= hs_nxt;
            sd_block_addr <= addr_nxt;
        end
    end

    // Next-state and datapath updates; sd_data only loads while sd_hndshk_o is low.
    always_comb begin
        state_nxt = state;
        word_nxt  = word_idx;
        byte_nxt  = byte_cnt;
        blk_nxt   = blk_idx;
        shreg_nxt = shreg;
        data_nxt  = sd_data;
        hs_nxt    = sd_hndshk_o;
        addr_nxt  = sd_block_addr;
        case (state)
            WAIT_INIT: begin
                if (!sd_busy) begin
                    state_nxt = (sd_error == 16'h0) ? IDLE : ERROR;
                end
            end
            IDLE, DONE: begin
                if (start) begin
                    state_nxt = FETCH;
                    word_nxt  = '0;
                    byte_nxt  = '0;
                    blk_nxt   = '0;
                end
            end
            FETCH: begin
                if (word_past || ram_rdy) begin
                    shreg_nxt = word_past ? 128'h0 : ram_data;
                    if (byte_cnt == 9'd0) begin
                        state_nxt = BLK_START;
                        addr_nxt  = blk_addr_fmt;
                    end else begin
                        state_nxt = BYTE_WAIT;
                    end
                end
            end
            BLK_START: begin
                if (sd_busy) begin
                    state_nxt = BYTE_WAIT;
                end
            end
            BYTE_WAIT: begin
                if (sd_hndshk_i) begin
                    data_nxt  = shreg[7:0];
                    hs_nxt    = 1'b1;
                    state_nxt = BYTE_ACK;
                end
            end
            BYTE_ACK: begin
                if (!sd_hndshk_i) begin
                    hs_nxt    = 1'b0;
                    byte_nxt  = byte_cnt + 9'd1;
                    shreg_nxt = shreg >> 8;
                    if (byte_cnt == 9'd511) begin
                        word_nxt  = word_idx + 23'd1;
                        state_nxt = BLK_END;
                    end else if (byte_cnt[3:0] == 4'hF) begin
                        word_nxt  = word_idx + 23'd1;
                        state_nxt = FETCH;
                    end else begin
                        state_nxt = BYTE_WAIT;
                    end
                end
            end
            BLK_END: begin
                if (!sd_busy) begin
                    if (sd_error != 16'h0) begin
                        state_nxt = ERROR;
                    end else begin
                        blk_nxt   = blk_idx + 32'd1;
                        state_nxt = word_past ? DONE : FETCH;
                    end
                end
            end
            ERROR: begin
                state_nxt = ERROR;
            end
            default: begin
                state_nxt = WAIT_INIT;
            end
        endcase
    end

endmodule
